// File: rtl/if_bundle_align.sv
// -----------------------------------------------------------------------------
// if_bundle_align
// Fetch-to-decode alignment stage. Buffers 64-bit fetch beats as halfwords,
// classifies the op at the queue head (16/32/48-bit, WEX chaining) and emits
// bundles of up to three ops, left-aligned, through a registered output stage.
//
// Ports
//   clock         core clock, rising edge
//   reset         asynchronous, active-high; clears all state
//   srWxe         WEX enable, sampled when a bundle is formed
//   ifWordIn      fetch beat, halfword 0 at [15:0] (lowest address)
//   ifWordValid   ifWordIn valid this cycle
//   ifWordReady   beat accepted this cycle (count <= 4 and no redirect)
//   ifRedirect    flush queue and output stage, restart at ifRedirectPc
//   ifRedirectPc  restart address (halfword aligned)
//   istrWord      aligned bundle: op1 [31:0], op2 [63:32], op3 [95:64]
//   idValid       istrWord / idPc / idStep valid
//   idReady       decoder consumes the bundle this cycle
//   idPc          address of the bundle's first halfword
//   idStep        bundle length in bytes (2, 4, 6, 8 or 12)
// -----------------------------------------------------------------------------
module if_bundle_align (
    input  logic        clock,
    input  logic        reset,
    input  logic        srWxe,
    input  logic [63:0] ifWordIn,
    input  logic        ifWordValid,
    output logic        ifWordReady,
    input  logic        ifRedirect,
    input  logic [31:0] ifRedirectPc,
    output logic [95:0] istrWord,
    output logic        idValid,
    input  logic        idReady,
    output logic [31:0] idPc,
    output logic [3:0]  idStep
);

    // Any op whose head halfword starts with 3'b111 is longer than 16 bits.
    function automatic logic isWide(input logic [15:0] h);
        return (h[15:13] == 3'b111);
    endfunction

    // EC..EF and FC..FF heads are 48-bit ops.
    function automatic logic is48(input logic [15:0] h);
        return (h[15:10] == 6'b111011) || (h[15:10] == 6'b111111);
    endfunction

    function automatic logic is32(input logic [15:0] h);
        return isWide(h) && !is48(h);
    endfunction

    // WEX chaining flag of a 32-bit op; the E0..EB range never chains.
    function automatic logic isWex(input logic [15:0] h, input logic wxe);
        logic wex;
        if (h[15:11] == 5'b11110) begin
            wex = h[10] && wxe;
        end else if (h[15:10] == 6'b111110) begin
            wex = h[8] && wxe;
        end else begin
            wex = 1'b0;
        end
        return wex;
    endfunction

    logic [15:0] queueR [8];
    logic [3:0]  countR;
    logic [31:0] pcR;
    logic [95:0] istrWordR;
    logic        idValidR;
    logic [31:0] idPcR;
    logic [3:0]  idStepR;

    logic        formS;
    logic [2:0]  lenS;
    logic [3:0]  stepS;
    logic        loadS;
    logic        pushS;
    logic [3:0]  popCntS;
    logic [3:0]  countNextS;
    logic [95:0] bundleS;
    logic [15:0] queueShiftS [8];
    logic [15:0] queueNextS [8];

    assign ifWordReady = (countR <= 4'd4) && !ifRedirect;
    assign istrWord    = istrWordR;
    assign idValid     = idValidR;
    assign idPc        = idPcR;
    assign idStep      = idStepR;

    // Bundle length decode from the head op; a WEX op needs the following
    // op's head halfword to be present before the length is known.
    always_comb begin
        formS = 1'b0;
        lenS  = 3'd2;
        if (!isWide(queueR[0])) begin
            lenS  = 3'd1;
            formS = (countR >= 4'd1);
        end else if (is48(queueR[0])) begin
            lenS  = 3'd3;
            formS = (countR >= 4'd3);
        end else if (!isWex(queueR[0], srWxe)) begin
            lenS  = 3'd2;
            formS = (countR >= 4'd2);
        end else if (countR < 4'd3) begin
            lenS  = 3'd2;
            formS = 1'b0;
        end else if (!is32(queueR[2])) begin
            lenS  = 3'd2;
            formS = 1'b1;
        end else if (!isWex(queueR[2], srWxe)) begin
            lenS  = 3'd4;
            formS = (countR >= 4'd4);
        end else if (countR < 4'd5) begin
            lenS  = 3'd4;
            formS = 1'b0;
        end else if (!is32(queueR[4])) begin
            lenS  = 3'd4;
            formS = 1'b1;
        end else begin
            lenS  = 3'd6;
            formS = (countR >= 4'd6);
        end
    end

    // Handshake decode and queue occupancy update.
    always_comb begin
        stepS      = {lenS, 1'b0};
        loadS      = formS && (!idValidR || idReady);
        pushS      = ifWordValid && ifWordReady;
        popCntS    = loadS ? {1'b0, lenS} : 4'd0;
        countNextS = countR - popCntS + (pushS ? 4'd4 : 4'd0);
    end

    // Contiguous halfwords make the bundle a masked copy of the queue head.
    always_comb begin
        bundleS = 96'd0;
        for (int i = 0; i < 6; i++) begin
            if (3'(i) < lenS) begin
                bundleS[16*i +: 16] = queueR[i];
            end else begin
                bundleS[16*i +: 16] = 16'd0;
            end
        end
    end

    // Pop: shift the queue down so the head stays at entry 0.
    always_comb begin
        logic [3:0] srcIdx;
        srcIdx = 4'd0;
        for (int i = 0; i < 8; i++) begin
            srcIdx = 4'(i) + popCntS;
            if (srcIdx < 4'd8) begin
                queueShiftS[i] = queueR[srcIdx[2:0]];
            end else begin
                queueShiftS[i] = 16'd0;
            end
        end
    end

    // Push: place the four beat halfwords right after the post-pop tail.
    always_comb begin
        logic [3:0] base;
        logic [3:0] off;
        base = countR - popCntS;
        off  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            off = 4'(i) - base;
            if (pushS && (4'(i) >= base) && (off < 4'd4)) begin
                queueNextS[i] = ifWordIn[{off[1:0], 4'b0000} +: 16];
            end else begin
                queueNextS[i] = queueShiftS[i];
            end
        end
    end

    // Halfword queue, occupancy and fetch pc; redirect flushes and restarts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            countR <= 4'd0;
            pcR    <= 32'd0;
            for (int i = 0; i < 8; i++) begin
                queueR[i] <= 16'd0;
            end
        end else if (ifRedirect) begin
            countR <= 4'd0;
            pcR    <= ifRedirectPc;
        end else begin
            countR <= countNextS;
            for (int i = 0; i < 8; i++) begin
                queueR[i] <= queueNextS[i];
            end
            if (loadS) begin
                pcR <= pcR + {28'd0, stepS};
            end else begin
                pcR <= pcR;
            end
        end
    end

    // Registered output stage; holds while the decoder stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idValidR  <= 1'b0;
            istrWordR <= 96'd0;
            idPcR     <= 32'd0;
            idStepR   <= 4'd0;
        end else if (ifRedirect) begin
            idValidR <= 1'b0;
        end else if (loadS) begin
            idValidR  <= 1'b1;
            istrWordR <= bundleS;
            idPcR     <= pcR;
            idStepR   <= stepS;
        end else if (idReady) begin
            idValidR <= 1'b0;
        end else begin
            idValidR <= idValidR;
        end
    end

endmodule

// File: tb/tb_if_bundle_align.sv
module tb_if_bundle_align;

    logic        clock;
    logic        reset;
    logic        srWxe;
    logic [63:0] ifWordIn;
    logic        ifWordValid;
    logic        ifWordReady;
    logic        ifRedirect;
    logic [31:0] ifRedirectPc;
    logic [95:0] istrWord;
    logic        idValid;
    logic        idReady;
    logic [31:0] idPc;
    logic [3:0]  idStep;

    typedef struct packed {
        logic [95:0] w;
        logic [31:0] pc;
        logic [3:0]  step;
    } expT;

    expT sbQ[$];
    expT monExp;
    int  vecCnt = 0;
    int  errCnt = 0;

    if_bundle_align dut (
        .clock       (clock),
        .reset       (reset),
        .srWxe       (srWxe),
        .ifWordIn    (ifWordIn),
        .ifWordValid (ifWordValid),
        .ifWordReady (ifWordReady),
        .ifRedirect  (ifRedirect),
        .ifRedirectPc(ifRedirectPc),
        .istrWord    (istrWord),
        .idValid     (idValid),
        .idReady     (idReady),
        .idPc        (idPc),
        .idStep      (idStep)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vecCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expectB(input logic [95:0] w, input logic [31:0] pc, input logic [3:0] st);
        expT e;
        e.w = w;
        e.pc = pc;
        e.step = st;
        sbQ.push_back(e);
    endtask

    // Monitor: a bundle is consumed on the edge after idValid && idReady.
    always @(negedge clock) begin
        if (!reset && !ifRedirect && idValid && idReady) begin
            if (sbQ.size() == 0) begin
                vecCnt++;
                errCnt++;
                $display("FAIL unexpectedBundle: actual istrWord=%0h idPc=%0h expected=none", istrWord, idPc);
            end else begin
                monExp = sbQ.pop_front();
                chk("istrWord", istrWord, monExp.w);
                chk("idPc", {64'd0, idPc}, {64'd0, monExp.pc});
                chk("idStep", {92'd0, idStep}, {92'd0, monExp.step});
            end
        end
    end

    task automatic sendBeat(input logic [63:0] w);
        logic acc;
        acc = 1'b0;
        ifWordIn = w;
        ifWordValid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clock);
            acc = ifWordReady;
            @(posedge clock);
            #1;
        end
        ifWordValid = 1'b0;
        chk("beatAccepted", {95'd0, acc}, 96'd1);
    endtask

    task automatic doRedirect(input logic [31:0] pc);
        ifRedirectPc = pc;
        ifRedirect = 1'b1;
        @(posedge clock);
        #1;
        ifRedirect = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sbQ.size() != 0; i++) @(posedge clock);
        repeat (2) @(posedge clock);
        #1;
        chk("drainEmpty", 96'(sbQ.size()), 96'd0);
        chk("idleValid", {95'd0, idValid}, 96'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] beats [4];
        int bi;
        logic acc;

        reset = 1'b1; srWxe = 1'b0; ifWordIn = 64'd0; ifWordValid = 1'b0;
        ifRedirect = 1'b0; ifRedirectPc = 32'd0; idReady = 1'b1;

        // Reset state
        #12;
        chk("rstValid", {95'd0, idValid}, 96'd0);
        chk("rstIstr", istrWord, 96'd0);
        chk("rstPc", {64'd0, idPc}, 96'd0);
        chk("rstStep", {92'd0, idStep}, 96'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rstReady", {95'd0, ifWordReady}, 96'd1);
        @(posedge clock);
        #1;

        // Four 16-bit ops
        doRedirect(32'h1000);
        expectB(96'h1234, 32'h1000, 4'd2);
        expectB(96'h3000, 32'h1002, 4'd2);
        expectB(96'h0,    32'h1004, 4'd2);
        expectB(96'h0,    32'h1006, 4'd2);
        sendBeat(64'h0000_0000_3000_1234);
        drain();

        // WEX pair vs. no WEX
        srWxe = 1'b1;
        expectB(96'h0_BBBBF000_AAAAF400, 32'h1008, 4'd8);
        sendBeat(64'hBBBB_F000_AAAA_F400);
        drain();
        srWxe = 1'b0;
        expectB(96'hAAAAF400, 32'h1010, 4'd4);
        expectB(96'hBBBBF000, 32'h1014, 4'd4);
        sendBeat(64'hBBBB_F000_AAAA_F400);
        drain();

        // Three-op bundle spanning two beats
        srWxe = 1'b1;
        doRedirect(32'h2000);
        expectB(96'h3333F000_2222F400_1111F400, 32'h2000, 4'd12);
        expectB(96'h0, 32'h200C, 4'd2);
        expectB(96'h0, 32'h200E, 4'd2);
        sendBeat(64'h2222_F400_1111_F400);
        sendBeat(64'h0000_0000_3333_F000);
        drain();

        // 48-bit op, F8..FB WEX via bit 8, non-32-bit op2, E-range never WEX
        expectB(96'h2222_1111_EC00, 32'h2010, 4'd6);
        expectB(96'h0005, 32'h2016, 4'd2);
        sendBeat(64'h0005_2222_1111_EC00);
        drain();
        expectB(96'h5555E000_4444F900, 32'h2018, 4'd8);
        sendBeat(64'h5555_E000_4444_F900);
        drain();
        expectB(96'h6666F400, 32'h2020, 4'd4);
        expectB(96'h0007, 32'h2024, 4'd2);
        expectB(96'h0008, 32'h2026, 4'd2);
        sendBeat(64'h0008_0007_6666_F400);
        drain();
        expectB(96'h7777E400, 32'h2028, 4'd4);
        expectB(96'h8888F000, 32'h202C, 4'd4);
        sendBeat(64'h8888_F000_7777_E400);
        drain();

        // Decoder stall with continuous beats
        idReady = 1'b0;
        doRedirect(32'h3000);
        beats[0] = 64'hBBBB_F000_AAAA_F400;
        beats[1] = 64'h0004_0003_0002_0001;
        beats[2] = 64'h0008_0007_0006_0005;
        beats[3] = 64'h000C_000B_000A_0009;
        bi = 0;
        for (int c = 0; c < 12; c++) begin
            ifWordValid = (bi < 4);
            if (bi < 4) ifWordIn = beats[bi];
            @(negedge clock);
            acc = ifWordReady && ifWordValid;
            if (idValid) chk("stallHold", istrWord, 96'h0_BBBBF000_AAAAF400);
            @(posedge clock);
            #1;
            if (acc) bi++;
        end
        chk("stallBeats", 96'(bi), 96'd3);
        chk("stallReady", {95'd0, ifWordReady}, 96'd0);
        chk("stallValid", {95'd0, idValid}, 96'd1);
        chk("stallPc", {64'd0, idPc}, 96'h3000);
        expectB(96'h0_BBBBF000_AAAAF400, 32'h3000, 4'd8);
        for (int k = 1; k <= 12; k++) expectB({80'd0, 16'(k)}, 32'h3008 + 32'(2 * (k - 1)), 4'd2);
        idReady = 1'b1;
        for (int c = 0; c < 40 && bi < 4; c++) begin
            ifWordValid = 1'b1;
            ifWordIn = beats[bi];
            @(negedge clock);
            acc = ifWordReady;
            @(posedge clock);
            #1;
            if (acc) bi++;
        end
        ifWordValid = 1'b0;
        chk("refillBeats", 96'(bi), 96'd4);
        drain();

        // Redirect while stalled drops the same-cycle beat
        idReady = 1'b0;
        sendBeat(64'h0014_0013_0012_0011);
        repeat (2) @(posedge clock);
        #1;
        chk("heldValid", {95'd0, idValid}, 96'd1);
        ifWordIn = 64'h0077_0066_0055_0044;
        ifWordValid = 1'b1;
        ifRedirectPc = 32'h4000;
        ifRedirect = 1'b1;
        @(negedge clock);
        chk("redirReady", {95'd0, ifWordReady}, 96'd0);
        @(posedge clock);
        #1;
        ifRedirect = 1'b0;
        ifWordValid = 1'b0;
        chk("redirValid", {95'd0, idValid}, 96'd0);
        idReady = 1'b1;
        expectB(96'h0099, 32'h4000, 4'd2);
        expectB(96'h0,    32'h4002, 4'd2);
        expectB(96'h0,    32'h4004, 4'd2);
        expectB(96'h0,    32'h4006, 4'd2);
        sendBeat(64'h0000_0000_0000_0099);
        drain();

        // Asynchronous reset mid-stream
        idReady = 1'b0;
        sendBeat(64'h0000_0000_0000_0042);
        repeat (2) @(posedge clock);
        #1;
        chk("preRstValid", {95'd0, idValid}, 96'd1);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("asyncValid", {95'd0, idValid}, 96'd0);
        chk("asyncReady", {95'd0, ifWordReady}, 96'd1);
        chk("asyncIstr", istrWord, 96'd0);
        chk("asyncPc", {64'd0, idPc}, 96'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        idReady = 1'b1;
        expectB(96'h0005, 32'h0, 4'd2);
        expectB(96'h0,    32'h2, 4'd2);
        expectB(96'h0,    32'h4, 4'd2);
        expectB(96'h0,    32'h6, 4'd2);
        sendBeat(64'h0000_0000_0000_0005);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/if_bundle_align.md
IF_BUNDLE_ALIGN -- requirements
Module: IfBundleAlign

Interface
REQ-001 SHALL have port clock, in, 1 bit: core clock; all state updates on rising edge.
REQ-002 SHALL have port reset, in, 1 bit: asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port srWxe, in, 1 bit: WEX enable; sampled when a bundle is formed.
REQ-004 SHALL have port ifWordIn, in, 64 bits: fetch beat of four halfwords; halfword 0 is [15:0] and is lowest address.
REQ-005 SHALL have port ifWordValid, in, 1 bit: ifWordIn is valid this cycle.
REQ-006 SHALL have port ifWordReady, out, 1 bit: the beat is accepted this cycle.
REQ-007 SHALL have port ifRedirect, in, 1 bit: flush and restart at ifRedirectPc.
REQ-008 SHALL have port ifRedirectPc, in, 32 bits: restart address, halfword aligned.
REQ-009 SHALL have port istrWord, out, 96 bits: aligned bundle; op1 at [31:0], op2 at [63:32], op3 at [95:64]; unused bits 0.
REQ-010 SHALL have port idValid, out, 1 bit: istrWord, idPc and idStep are valid.
REQ-011 SHALL have port idReady, in, 1 bit: the decoder consumes the bundle this cycle.
REQ-012 SHALL have port idPc, out, 32 bits: address of the bundle's first halfword.
REQ-013 SHALL have port idStep, out, 4 bits: bundle length in bytes (2, 4, 6, 8 or 12).

Function
REQ-014 SHALL hold a halfword queue of 8 entries with count 0..8; no pointer wrap is visible; head is always the oldest halfword.
REQ-015 SHALL drive ifWordReady = (count <= 4) && !ifRedirect, combinationally from the registered count.
REQ-016 SHALL, on ifWordValid && ifWordReady, append halfwords 0..3 in order after any same-cycle pop.
REQ-017 SHALL classify an op by its head halfword h:
- h[15:13] != 3'b111: 16-bit.
- h[15:10] in {111011, 111111} (EC..EF, FC..FF): 48-bit, never WEX.
- All other values: 32-bit.
REQ-018 SHALL set a 32-bit op's WEX flag as follows; E0..EB are never WEX:
- F0..F7: h[10] && srWxe.
- F8..FB: h[8] && srWxe.
REQ-019 SHALL form bundles as follows:
- op1 WEX: op2 (at halfword 2) follows.
- op2 32-bit and WEX: op3 (at halfword 4) follows.
- Maximum of 3 ops.
- An op2 or op3 that is not 32-bit ends the bundle before that op, and the bundle is emitted without it.
REQ-020 SHALL form a bundle only when count >= its full halfword length; otherwise no bundle is formed and the queue waits.
REQ-021 SHALL register outputs: the output stage loads when (!idValid || idReady) and a bundle is formed; on load, pop the bundle's halfwords, set idPc = current pc, set idStep, and advance pc by idStep (modulo 2^32).
REQ-022 SHALL keep istrWord, idPc and idStep stable while idValid && !idReady.
REQ-023 SHALL clear idValid after consumption when no new bundle loads in the same cycle.
REQ-024 SHALL support push and pop in one cycle; count_next = count - popped + 4*pushed; count_next shall never exceed 8.
REQ-025 SHALL, on ifRedirect, do the following, taking priority over any same-cycle push, pop or load:
- Set count to 0, idValid to 0 and pc to ifRedirectPc.
- Drop the same-cycle beat.
REQ-026 SHALL fill istrWord halfwords beyond the bundle length with 0 (a 48-bit op occupies [47:0]).

Reset
REQ-027 SHALL, while reset is high, set: count=0, pc=0, idValid=0, istrWord=0, idPc=0, idStep=0.
REQ-028 SHALL, on reset deassertion, drive ifWordReady=1 in the first cycle.

Verification
REQ-029 SHALL cover: assert reset mid-stream with idValid=1 -> idValid=0 and ifWordReady=1 immediately, independent of clock.
REQ-030 SHALL cover: redirect 0x1000, then beat 64'h0000_0000_3000_1234 with idReady=1 -> four bundles:
- istrWord 96'h1234, 96'h3000, 0, 0.
- idPc 1000, 1002, 1004, 1006.
- idStep 2 each.
REQ-031 SHALL cover: srWxe=1, beat 64'hBBBB_F000_AAAA_F400 -> one bundle 96'h0_BBBBF000_AAAAF400, idStep 8; with srWxe=0 -> two bundles of idStep 4.
REQ-032 SHALL cover: srWxe=1, beats 64'h2222_F400_1111_F400 and 64'h0000_0000_3333_F000 -> bundle 96'h3333F000_2222F400_1111F400, idStep 12, next bundle 96'h0000 at pc+12.
REQ-033 SHALL cover: idReady=0 with continuous beats -> exactly two beats accepted after the held bundle (count 8, ifWordReady=0); istrWord stable; releasing idReady restores ifWordReady once count <= 4.
REQ-034 SHALL cover: ifRedirect with ifWordValid=1 while stalled -> beat dropped, idValid=0 next cycle, next bundle idPc = ifRedirectPc.
